// File: rtl/tx_ethernet.sv
// GMII Ethernet II transmitter: preamble/SFD, header, payload, zero pad, FCS, then inter-frame gap.
// Optional 802.1Q tagging is compiled in with `define TX_VLAN_EN (adds tx_vlan_tci).
module tx_ethernet #(
    parameter int           OCT         = 8,
    parameter logic [OCT-1:0] PRE       = 8'b10101010,
    parameter logic [OCT-1:0] SFD       = 8'b10101011,
    parameter int           MIN_PAYLOAD = 46,
    parameter int           MAX_PAYLOAD = 1500,
    parameter int           IFG_CYCLES  = 12
) (
    input  logic           TX_CLK,
    input  logic           rst,
    input  logic [47:0]    mac_addr,
    input  logic [47:0]    tx_mac_dst,
    input  logic [15:0]    tx_ethertype,
`ifdef TX_VLAN_EN
    input  logic [15:0]    tx_vlan_tci,
`endif
    input  logic           tx_start,
    output logic           tx_busy,
    input  logic           tx_payload_v,
    input  logic [OCT-1:0] tx_payload,
    input  logic           tx_payload_last,
    output logic           tx_payload_ready,
    output logic           tx_done,
    output logic           tx_err,
    output logic           TX_EN,
    output logic [OCT-1:0] TXD,
    output logic           TX_ER
);

`ifdef TX_VLAN_EN
    localparam int MIN_EFF   = MIN_PAYLOAD - 4;
    localparam int HDR_BYTES = 18;
`else
    localparam int MIN_EFF   = MIN_PAYLOAD;
    localparam int HDR_BYTES = 14;
`endif
    localparam int HDR_W = HDR_BYTES * OCT;

    typedef enum logic [3:0] {
        ST_IDLE, ST_PRE, ST_SFD, ST_DST, ST_SRC,
`ifdef TX_VLAN_EN
        ST_VLAN,
`endif
        ST_TYPE, ST_PAYLOAD, ST_PAD, ST_FCS, ST_ABORT, ST_IFG
    } state_t;

    state_t           state, nxt;
    logic [7:0]       cnt, cnt_n, cnt_inc;
    logic [10:0]      pcnt, pcnt_n, pcnt_inc;
    logic [31:0]      crc, crc_n, fcs;
    logic             ovs, ovs_n;
    logic [HDR_W-1:0] hdr, hdr_n, hdr_ld;
    logic             en_n, er_n, done_n, err_n, busy_n, crc_upd;
    logic [OCT-1:0]   txd_n;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [OCT-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < OCT; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Whole header is latched as one shift register, sent MSB byte first.
`ifdef TX_VLAN_EN
    assign hdr_ld = {tx_mac_dst, mac_addr, 16'h8100, tx_vlan_tci, tx_ethertype};
`else
    assign hdr_ld = {tx_mac_dst, mac_addr, tx_ethertype};
`endif

    assign fcs              = ~crc;
    assign tx_payload_ready = (state == ST_PAYLOAD);

    // state names the phase whose byte is registered onto TXD at the next edge
    always_comb begin
        nxt      = state;
        cnt_n    = cnt;
        pcnt_n   = pcnt;
        crc_n    = crc;
        ovs_n    = ovs;
        hdr_n    = hdr;
        en_n     = 1'b0;
        er_n     = 1'b0;
        txd_n    = '0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        crc_upd  = 1'b0;
        cnt_inc  = cnt + 8'd1;
        pcnt_inc = pcnt + 11'd1;
        case (state)
            ST_IDLE: if (tx_start) begin
                hdr_n = hdr_ld;
                en_n  = 1'b1;
                txd_n = PRE;
                nxt   = ST_PRE;
                cnt_n = 8'd1;
            end
            ST_PRE: begin
                en_n  = 1'b1;
                txd_n = PRE;
                if (cnt == 8'd6) begin nxt = ST_SFD; cnt_n = '0; end
                else cnt_n = cnt_inc;
            end
            ST_SFD: begin
                en_n   = 1'b1;
                txd_n  = SFD;
                crc_n  = '1;
                pcnt_n = '0;
                ovs_n  = 1'b0;
                nxt    = ST_DST;
                cnt_n  = '0;
            end
`ifdef TX_VLAN_EN
            ST_DST, ST_SRC, ST_VLAN, ST_TYPE: begin
`else
            ST_DST, ST_SRC, ST_TYPE: begin
`endif
                en_n    = 1'b1;
                txd_n   = hdr[HDR_W-1 -: OCT];
                hdr_n   = hdr << OCT;
                crc_upd = 1'b1;
                cnt_n   = cnt_inc;
                if (state == ST_DST && cnt == 8'd5) begin nxt = ST_SRC; cnt_n = '0; end
`ifdef TX_VLAN_EN
                if (state == ST_SRC && cnt == 8'd5) begin nxt = ST_VLAN; cnt_n = '0; end
                if (state == ST_VLAN && cnt == 8'd3) begin nxt = ST_TYPE; cnt_n = '0; end
`else
                if (state == ST_SRC && cnt == 8'd5) begin nxt = ST_TYPE; cnt_n = '0; end
`endif
                if (state == ST_TYPE && cnt == 8'd1) begin nxt = ST_PAYLOAD; cnt_n = '0; end
            end
            ST_PAYLOAD: begin
                en_n = 1'b1;
                if (tx_payload_v) begin
                    txd_n   = tx_payload;
                    crc_upd = 1'b1;
                    pcnt_n  = pcnt_inc;
                    if (tx_payload_last)
                        nxt = (pcnt_inc < 11'(MIN_EFF)) ? ST_PAD : ST_FCS;
                    else if (pcnt_inc == 11'(MAX_PAYLOAD)) begin
                        nxt   = ST_FCS;
                        ovs_n = 1'b1;
                    end
                end else begin
                    // underrun: this edge already drives the first abort byte
                    er_n  = 1'b1;
                    nxt   = ST_ABORT;
                    cnt_n = 8'd1;
                end
            end
            ST_PAD: begin
                en_n    = 1'b1;
                crc_upd = 1'b1;
                pcnt_n  = pcnt_inc;
                if (pcnt_inc == 11'(MIN_EFF)) begin nxt = ST_FCS; cnt_n = '0; end
            end
            ST_FCS: begin
                en_n  = 1'b1;
                txd_n = fcs[{cnt[1:0], 3'b000} +: OCT];
                cnt_n = cnt_inc;
                if (cnt == 8'd3) begin
                    done_n = 1'b1;
                    err_n  = ovs;
                    nxt    = ST_IFG;
                    cnt_n  = '0;
                end
            end
            ST_ABORT: begin
                en_n  = 1'b1;
                er_n  = 1'b1;
                cnt_n = cnt_inc;
                if (cnt == 8'd3) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                    nxt    = ST_IFG;
                    cnt_n  = '0;
                end
            end
            ST_IFG: begin
                cnt_n = cnt_inc;
                if (cnt == 8'(IFG_CYCLES - 1)) begin nxt = ST_IDLE; cnt_n = '0; end
            end
            default: nxt = ST_IDLE;
        endcase
        if (crc_upd) crc_n = crc_byte(crc, txd_n);
        busy_n = (nxt != ST_IDLE) || (state == ST_IFG);
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pcnt    <= '0;
            crc     <= '1;
            ovs     <= 1'b0;
            hdr     <= '0;
            TX_EN   <= 1'b0;
            TX_ER   <= 1'b0;
            TXD     <= '0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            tx_busy <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_n;
            pcnt    <= pcnt_n;
            crc     <= crc_n;
            ovs     <= ovs_n;
            hdr     <= hdr_n;
            TX_EN   <= en_n;
            TX_ER   <= er_n;
            TXD     <= txd_n;
            tx_done <= done_n;
            tx_err  <= err_n;
            tx_busy <= busy_n;
        end
    end

endmodule

// File: doc/tx_ethernet.md
Name: tx_ethernet

Overview:
GMII Ethernet II frame transmitter, the transmit counterpart of rx_ethernet. It accepts a frame request (destination MAC, ethertype) and a byte-stream payload from an upper layer (future tx_ipv4). It emits preamble, SFD, header, payload, zero padding and FCS on TXD/TX_EN/TX_ER, then enforces the inter-frame gap. It sits between the tx protocol stack and the GMII pins in top.

Parameters:
OCT, 8, byte width.
PRE, 8'b10101010, preamble byte, driven on TXD exactly as given, matching the rx_ethernet compare value.
SFD, 8'b10101011, start-frame-delimiter byte, driven exactly as given.
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded.
MAX_PAYLOAD, 1500, maximum payload bytes accepted per frame.
IFG_CYCLES, 12, idle cycles after the last FCS byte.

Ports:
TX_CLK  input  1  transmit clock, 125 MHz; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
mac_addr  input  48  source MAC from the CSR; [47:40] is sent first.
tx_mac_dst  input  48  destination MAC; [47:40] is sent first.
tx_ethertype  input  16  ethertype; [15:8] is sent first.
tx_start  input  1  frame request; sampled only in IDLE.
tx_busy  output  1  high from tx_start acceptance through the end of IFG.
tx_payload_v  input  1  payload byte valid.
tx_payload  input  8  payload byte.
tx_payload_last  input  1  marks the final payload byte.
tx_payload_ready  output  1  block consumes tx_payload this cycle when both v and ready are high.
tx_done  output  1  one-cycle pulse on the cycle of the last FCS byte (or last ABORT byte).
tx_err  output  1  one-cycle pulse coincident with tx_done when the frame was aborted or truncated.
TX_EN  output  1  GMII transmit enable, registered.
TXD  output  8  GMII data, registered.
TX_ER  output  1  GMII transmit error, registered.

Behaviour:
- Reset (async): state=IDLE. TX_EN, TX_ER, tx_busy, tx_done, tx_err, tx_payload_ready = 0; TXD=8'h00; CRC=32'hFFFFFFFF.
- On tx_start in IDLE: latch tx_mac_dst, mac_addr and tx_ethertype. tx_busy=1 next cycle. TX_EN=1 with TXD=PRE on that same next cycle.
- States and byte counts:
  - PRE: 7 bytes.
  - SFD: 1 byte.
  - DST: 6 bytes.
  - SRC: 6 bytes.
  - TYPE: 2 bytes.
  - PAYLOAD: variable length.
  - PAD: until payload plus pad equals MIN_PAYLOAD.
  - FCS: 4 bytes.
  - IFG: IFG_CYCLES cycles.
  - ABORT: see below.
  - After IFG, return to IDLE.
- tx_payload_ready is combinational, high only in PAYLOAD. The accepted byte appears on TXD the following cycle.
- Payload handshake rules:
  - Upstream must hold tx_payload_v high continuously from the first PAYLOAD cycle until the last byte.
  - The byte with tx_payload_last ends PAYLOAD.
  - If fewer than MIN_PAYLOAD bytes were sent, go to PAD (TXD=8'h00); otherwise go to FCS.
- Underrun: tx_payload_v=0 in PAYLOAD → ABORT. ABORT drives TX_EN=1, TX_ER=1, TXD=8'h00 for 4 cycles, then pulses tx_done and tx_err, then enters IFG.
- Oversize: after MAX_PAYLOAD bytes are accepted without last, ready drops. The frame is closed normally (PAD skipped, FCS sent), and tx_err pulses with tx_done.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated LSB-first over DST through PAD.
  - FCS = ~CRC, sent least-significant byte first.
  - CRC is reinitialised in SFD.
- Total on-wire length for an N-byte payload = 8 + 14 + max(N, 46) + 4 bytes.
- IFG: TX_EN=0, TX_ER=0, TXD=8'h00. tx_start is ignored until IDLE.
- tx_start while busy is ignored (not queued).
- Header inputs may change after acceptance without effect.

Optional Feature:
Macro TX_VLAN_EN.
- Defined:
  - Adds port tx_vlan_tci input 16.
  - A VLAN state after SRC sends 8'h81, 8'h00, tci[15:8], tci[7:0], all included in the CRC.
  - MIN_PAYLOAD behaviour becomes 42 bytes.
- Undefined: no VLAN port or state; untagged frames only.

Test Plan:
- 64-byte payload: dst FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800, payload 0x00..0x3F → PRE×7 and SFD appear one cycle after tx_start, then header and payload in order; TX_EN high for exactly 90 cycles; CRC over DST..FCS gives residue 0xDEBB20E3; tx_done on the 90th byte.
- 10-byte payload → 36 pad bytes of 0x00, TX_EN high for 72 cycles, FCS matches the reference model.
- Underrun: tx_payload_v drops after byte 5 → 4 cycles with TX_ER=1 and TX_EN=1; tx_done and tx_err pulse together; TX_EN=0 afterwards.
- Back-to-back: tx_start held high → second frame's PRE appears exactly 12 idle cycles after the first frame's last FCS byte.
- Oversize: 1501 bytes offered → ready low after 1500 bytes, FCS sent, tx_err=1.
- Reset asserted mid-PAYLOAD → TX_EN=0, TX_ER=0, TXD=0 immediately (asynchronously); a new tx_start after release sends a clean frame.
